// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcode values,
// datapath widths, FSM state encoding and select-advance helpers.
package alu_pkg;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 4;

    localparam logic [SW-1:0] OP_ADD    = 4'd0;
    localparam logic [SW-1:0] OP_SUB    = 4'd1;
    localparam logic [SW-1:0] OP_X2     = 4'd2;
    localparam logic [SW-1:0] OP_DIV2   = 4'd3;
    localparam logic [SW-1:0] OP_AND    = 4'd4;
    localparam logic [SW-1:0] OP_OR     = 4'd5;
    localparam logic [SW-1:0] OP_XOR    = 4'd6;
    localparam logic [SW-1:0] OP_NOT    = 4'd7;
    localparam logic [SW-1:0] OP_EQ     = 4'd8;
    localparam logic [SW-1:0] OP_GT     = 4'd9;
    localparam logic [SW-1:0] OP_LT     = 4'd10;
    localparam logic [SW-1:0] OP_MAX    = 4'd11;
    localparam logic [SW-1:0] OP_KNIGHT = 4'd12;
    localparam logic [SW-1:0] OP_LAST   = OP_KNIGHT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DONE
    } state_e;

    function automatic logic op_legal(input logic [SW-1:0] op);
        return op <= OP_LAST;
    endfunction

    // The mux has no arm above OP_LAST, so stepping wraps to OP_ADD.
    function automatic logic [SW-1:0] next_sel(input logic [SW-1:0] s);
        return (s == OP_LAST) ? OP_ADD : s + SW'(1);
    endfunction

endpackage

// File: rtl/alu_settle_timer.sv
// Loadable down-counter with zero flag; holds at zero.
// Ports: clk, rst (sync, high), load_i/value_i, dec_i, zero_o.
module alu_settle_timer
    import alu_pkg::*;
#(
    parameter int unsigned W = CW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered front end for the 8-bit ALU result mux: accepts a request,
// drives operands/select, waits SETTLE cycles, captures the mux result.
// Ports: clk, rst, load, a_in, b_in, op_in, mux_o in; a_out, b_out, sel,
// result, valid, busy, err out. ALU_AUTOCYCLE_EN adds input auto_run.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef ALU_AUTOCYCLE_EN
    input  logic          auto_run,
`endif
    input  logic          load,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    input  logic [SW-1:0] op_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [SW-1:0] sel,
    input  logic [DW-1:0] mux_o,
    output logic [DW-1:0] result,
    output logic          valid,
    output logic          busy,
    output logic          err
);

    state_e        state_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [SW-1:0] sel_q;
    logic [DW-1:0] res_q;
    logic          valid_q;
    logic          busy_q;
    logic          err_q;

    logic          idle;
    logic          take_load;
    logic          auto_go;
    logic          start;
    logic          settled;

`ifdef ALU_AUTOCYCLE_EN
    // load wins over auto_run in the same cycle.
    assign auto_go = auto_run & ~load;
`else
    assign auto_go = 1'b0;
`endif

    assign idle      = (state_q == ST_IDLE);
    assign take_load = load & op_legal(op_in);
    assign start     = idle & (take_load | auto_go);

    alu_settle_timer #(
        .W (CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (start),
        .value_i (CW'(SETTLE - 1)),
        .dec_i   (state_q == ST_DRIVE),
        .zero_o  (settled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (take_load) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        sel_q   <= op_in;
                        busy_q  <= 1'b1;
                        state_q <= ST_DRIVE;
                    end else if (load) begin
                        err_q <= 1'b1;
                    end else if (auto_go) begin
                        sel_q   <= next_sel(sel_q);
                        busy_q  <= 1'b1;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (settled) begin
                        res_q   <= mux_o;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_out  = a_q;
    assign b_out  = b_q;
    assign sel    = sel_q;
    assign result = res_q;
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered front end for the 8-bit ALU result multiplexer. Accepts an operation request (two operands plus 4-bit opcode) through a load handshake, drives the operand buses and the 4-bit select into the ALU/mux datapath, waits a programmable settle time, then captures the selected 8-bit result with a one-cycle valid strobe. Sits between the board input logic (switches/buttons) and the combinational ALU + result mux; it owns the select lines that the mux consumes.

## Interface
- SETTLE, default 1: cycles the select/operands are held before the result is sampled (1..15).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  request strobe; accepted only when busy=0.
- a_in  in  8  operand A request.
- b_in  in  8  operand B request.
- op_in  in  4  requested opcode, 0..12 legal.
- a_out  out  8  registered operand A to ALU.
- b_out  out  8  registered operand B to ALU.
- sel  out  4  registered select to result mux.
- mux_o  in  8  selected result returned from the mux.
- result  out  8  captured result, held until next capture.
- valid  out  1  one-cycle pulse: result updated this cycle.
- busy  out  1  high while a request is in flight.
- err  out  1  one-cycle pulse: illegal opcode rejected.
- auto_run  in  1  present only with ALU_AUTOCYCLE_EN (see Configuration).

## Operation
- Opcodes: 0 add, 1 sub, 2 x2, 3 /2, 4 and, 5 or, 6 xor, 7 not, 8 eq, 9 gt, 10 lt, 11 max, 12 knight rider. 13..15 illegal (mux has no default arm).
- FSM states: IDLE, DRIVE, DONE.
- IDLE: busy=0. load=1 and op_in<=12 -> a_out<=a_in, b_out<=b_in, sel<=op_in, counter<=SETTLE-1, go DRIVE. load=1 and op_in>=13 -> err pulses next cycle, a_out/b_out/sel unchanged, stay IDLE.
- DRIVE: busy=1; counter decrements each cycle; on the cycle counter=0, result<=mux_o, go DONE.
- DONE: busy=1, valid=1 for exactly one cycle, then IDLE.
- load while busy=1 is ignored (not queued).
- sel, a_out, b_out hold their last value in IDLE; result holds until next capture.
- Reset values: a_out=0, b_out=0, sel=0, result=0, valid=0, busy=0, err=0, state IDLE, counter 0.
- rst in any state (including mid-DRIVE) aborts: no valid pulse, all outputs to reset values next cycle.

## Timing
- load sampled at edge k (IDLE) -> sel/a_out/b_out change after edge k; busy high from cycle k+1.
- result captured at edge k+SETTLE; valid high during cycle k+SETTLE+1; busy falls after edge k+SETTLE+1.
- Earliest next accept: edge k+SETTLE+2. Throughput one op per SETTLE+2 cycles.
- err: illegal load at edge k -> err high during cycle k+1 only; next load may be accepted at edge k+1.
- SETTLE=1 -> valid 2 cycles after accept edge.

## Configuration
- ALU_AUTOCYCLE_EN defined: auto_run port exists. In IDLE with auto_run=1 and load=0, sequencer starts an op using last a_out/b_out with sel = (previous sel == 12) ? 0 : previous sel+1; wraps 12->0, never emits 13..15. load has priority over auto_run in the same cycle. Dropping auto_run finishes the in-flight op, then stays IDLE.
- Not defined: no auto_run port; ops start only on load; behaviour otherwise identical.

## Structure
- Shared package alu_pkg: opcode localparams OP_ADD..OP_KNIGHT, OP_LAST=12, operand width 8, select width 4, FSM state enum.
- One sub-module: alu_settle_timer (loadable down-counter with zero flag), reused by the display-refresh logic.

## Test plan
- SETTLE=1, load a_in=5, b_in=3, op_in=0, bench mux model = a+b -> sel=0, valid exactly 2 cycles after accept, result=8, busy low the cycle after.
- load op_in=13 with sel previously 4 -> err one-cycle pulse, no valid, sel stays 4, busy never rises.
- Accepted op 1 (a=9, b=4), second load (op 5) during busy -> second ignored; single valid with result=5, sel stays 1.
- SETTLE=4, load op 11 a=0x20 b=0x7F, rst asserted in 2nd DRIVE cycle -> no valid, all outputs 0 next cycle, state IDLE.
- ALU_AUTOCYCLE_EN, sel=11, auto_run held high -> sel sequence 12, 0, 1 with one valid per op; load op 7 arriving with auto_run -> sel=7 taken first.
